// File: rtl/gpr_file.sv
// PIC10F200 general-purpose register file: 16 x 8-bit GPRs at 0x10-0x1F,
// with single-level INDF indirection through FSR.
module gpr_file (
  input  logic       clk,
  input  logic       rst,
  input  logic [4:0] f_addr,
  input  logic [4:0] fsr_bus,
  input  logic       wr_en,
  input  logic [7:0] alu_bus,
  output logic [4:0] eff_addr,
  output logic       gpr_sel,
  output logic [7:0] rd_data
);

  logic [7:0] mem [0:15];

  // INDF with FSR=0 resolves to 0x00 naturally and is never re-resolved.
  assign eff_addr = (f_addr == 5'h00) ? fsr_bus : f_addr;
  assign gpr_sel  = eff_addr[4];
  assign rd_data  = gpr_sel ? mem[eff_addr[3:0]] : 8'h00;

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 16; i++) begin
        mem[i] <= 8'h00;
      end
    end else if (wr_en && gpr_sel) begin
      mem[eff_addr[3:0]] <= alu_bus;
    end
  end

endmodule

// File: tb/tb_gpr_file.sv
// Scoreboard bench for gpr_file: stimulus queues hand-computed expectations,
// a negedge monitor pops and compares them against the DUT outputs.
module tb_gpr_file;

  logic       clk;
  logic       rst;
  logic [4:0] f_addr;
  logic [4:0] fsr_bus;
  logic       wr_en;
  logic [7:0] alu_bus;
  logic [4:0] eff_addr;
  logic       gpr_sel;
  logic [7:0] rd_data;

  typedef struct {
    string      name;
    logic [4:0] eff;
    logic       sel;
    logic [7:0] rd;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;

  gpr_file dut (
    .clk      (clk),
    .rst      (rst),
    .f_addr   (f_addr),
    .fsr_bus  (fsr_bus),
    .wr_en    (wr_en),
    .alu_bus  (alu_bus),
    .eff_addr (eff_addr),
    .gpr_sel  (gpr_sel),
    .rd_data  (rd_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Monitor: inputs are stable from posedge+1 to the next posedge, so the
  // negedge sees the pre-write combinational view of each queued step.
  always @(negedge clk) begin
    while (exp_q.size() > 0) begin
      exp_t e;
      e = exp_q.pop_front();
      checkOutput(e);
    end
  end

  task automatic checkOutput(input exp_t e);
    checks++;
    if (eff_addr !== e.eff || gpr_sel !== e.sel || rd_data !== e.rd) begin
      errors++;
      $display("[TB] FAIL %s: got eff=%h sel=%b rd=%h, expected eff=%h sel=%b rd=%h",
               e.name, eff_addr, gpr_sel, rd_data, e.eff, e.sel, e.rd);
    end
  endtask

  // Drive one cycle of inputs; any write lands on the posedge ending the cycle.
  task automatic applyStimulus(input string name, input logic r, input logic [4:0] f,
                               input logic [4:0] fsr, input logic we, input logic [7:0] d,
                               input logic [4:0] x_eff, input logic x_sel, input logic [7:0] x_rd);
    exp_t e;
    @(posedge clk);
    #1;
    rst     = r;
    f_addr  = f;
    fsr_bus = fsr;
    wr_en   = we;
    alu_bus = d;
    e.name = name;
    e.eff  = x_eff;
    e.sel  = x_sel;
    e.rd   = x_rd;
    exp_q.push_back(e);
  endtask

  initial begin
    int drain;
    rst = 1'b1; f_addr = 5'h10; fsr_bus = 5'h00; wr_en = 1'b0; alu_bus = 8'h00;
    @(posedge clk);
    #1;

    applyStimulus("reset_state", 0, 5'h10, 5'h00, 0, 8'h00, 5'h10, 1, 8'h00);

    for (int i = 0; i < 16; i++) begin
      applyStimulus("fill_a5", 0, 5'(16 + i), 5'h00, 1, 8'hA5, 5'(16 + i), 1, 8'h00);
    end
    applyStimulus("fill_rd_1f", 0, 5'h1F, 5'h00, 0, 8'h00, 5'h1F, 1, 8'hA5);
    applyStimulus("fill_rd_10", 0, 5'h10, 5'h00, 0, 8'h00, 5'h10, 1, 8'hA5);

    applyStimulus("rst_over_wr", 1, 5'h15, 5'h00, 1, 8'hFF, 5'h15, 1, 8'hA5);
    for (int i = 0; i < 16; i++) begin
      applyStimulus("rst_clear", 0, 5'(16 + i), 5'h00, 0, 8'h00, 5'(16 + i), 1, 8'h00);
    end

    applyStimulus("direct_wr", 0, 5'h13, 5'h00, 1, 8'h3C, 5'h13, 1, 8'h00);
    applyStimulus("direct_rd", 0, 5'h13, 5'h00, 0, 8'h00, 5'h13, 1, 8'h3C);
    applyStimulus("direct_nb", 0, 5'h14, 5'h00, 0, 8'h00, 5'h14, 1, 8'h00);
    applyStimulus("fsr_ignored", 0, 5'h13, 5'h1F, 0, 8'h00, 5'h13, 1, 8'h3C);

    applyStimulus("indir_wr", 0, 5'h00, 5'h1F, 1, 8'h81, 5'h1F, 1, 8'h00);
    applyStimulus("indir_dir_rd", 0, 5'h1F, 5'h00, 0, 8'h00, 5'h1F, 1, 8'h81);
    applyStimulus("indir_rd", 0, 5'h00, 5'h1F, 0, 8'h00, 5'h1F, 1, 8'h81);

    applyStimulus("null_indir_wr", 0, 5'h00, 5'h00, 1, 8'h55, 5'h00, 0, 8'h00);
    applyStimulus("null_chk_10", 0, 5'h10, 5'h00, 0, 8'h00, 5'h10, 1, 8'h00);
    applyStimulus("null_chk_13", 0, 5'h13, 5'h00, 0, 8'h00, 5'h13, 1, 8'h3C);
    applyStimulus("null_chk_1f", 0, 5'h1F, 5'h00, 0, 8'h00, 5'h1F, 1, 8'h81);

    applyStimulus("sfr_wr_0a", 0, 5'h0A, 5'h00, 1, 8'h77, 5'h0A, 0, 8'h00);
    applyStimulus("sfr_rd_0a", 0, 5'h0A, 5'h00, 0, 8'h00, 5'h0A, 0, 8'h00);
    applyStimulus("no_alias_1a", 0, 5'h1A, 5'h00, 0, 8'h00, 5'h1A, 1, 8'h00);
    applyStimulus("sfr_rd_06", 0, 5'h06, 5'h00, 0, 8'h00, 5'h06, 0, 8'h00);

    applyStimulus("rdw_pre", 0, 5'h12, 5'h00, 1, 8'h10, 5'h12, 1, 8'h00);
    applyStimulus("rdw_old", 0, 5'h12, 5'h00, 1, 8'h20, 5'h12, 1, 8'h10);
    applyStimulus("rdw_new", 0, 5'h12, 5'h00, 0, 8'h00, 5'h12, 1, 8'h20);

    applyStimulus("fsr_old_wr", 0, 5'h00, 5'h11, 1, 8'h99, 5'h11, 1, 8'h00);
    applyStimulus("fsr_new_12", 0, 5'h00, 5'h12, 0, 8'h00, 5'h12, 1, 8'h20);
    applyStimulus("fsr_old_11", 0, 5'h11, 5'h12, 0, 8'h00, 5'h11, 1, 8'h99);

    drain = 0;
    while (exp_q.size() > 0 && drain < 10) begin
      @(posedge clk);
      drain++;
    end
    @(posedge clk);
    if (exp_q.size() > 0) begin
      checks++;
      errors++;
      $display("[TB] FAIL drain: %0d expectations left, expected 0", exp_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
